// File: rtl/rect_plotter_pkg.sv
// rect_plotter_pkg: screen geometry, coordinate/colour widths and colour constants
package rect_plotter_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam logic [C_W-1:0] BLACK = 3'd0;
  localparam logic [C_W-1:0] WHITE = 3'd7;
endpackage

// File: rtl/rect_plotter_raster_counter.sv
// raster_counter: raster-order column/row counter with wrap and last-pixel flags
module raster_counter
  import rect_plotter_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           wrap,
  output logic           last
);
  assign wrap = cx == w - X_W'(1);
  assign last = wrap && cy == h - Y_W'(1);
  // step one pixel per enabled cycle, wrapping to the next row at the right edge
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clr) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      cx <= wrap ? '0 : cx + X_W'(1);
      cy <= wrap ? cy + Y_W'(1) : cy;
    end
endmodule

// File: rtl/rect_plotter.sv
// rect_plotter: fills a rectangle on the VGA adapter, one pixel per cycle, clipping off-screen pixels
module rect_plotter
  import rect_plotter_pkg::*;
#(
  parameter int SCREEN_W = rect_plotter_pkg::SCREEN_W,
  parameter int SCREEN_H = rect_plotter_pkg::SCREEN_H
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           abort,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [X_W-1:0] w_in,
  input  logic [Y_W-1:0] h_in,
  input  logic [C_W-1:0] colour_in,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_nx;
  logic [X_W-1:0] x0, w0, cx, hx;
  logic [Y_W-1:0] y0, h0, cy, hy;
  logic [C_W-1:0] c0, hc;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  logic accept, draw, wrap, last;
  assign accept = state == IDLE && start && !abort;
  assign draw = state == DRAW;
  assign sx = {1'b0, x0} + {1'b0, cx};
  assign sy = {1'b0, y0} + {1'b0, cy};
  raster_counter u_cnt (
    .clk(clk), .resetn(resetn), .clr(accept), .en(draw),
    .w(w0), .h(h0), .cx(cx), .cy(cy), .wrap(wrap), .last(last)
  );
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // next state: zero-sized requests skip straight to DONE, abort beats everything
  always_comb
    state_nx = state == IDLE ? (accept ? ((w_in == '0 || h_in == '0) ? DONE : DRAW) : IDLE) :
               state == DRAW ? (abort ? IDLE : last ? DONE : DRAW) : IDLE;
  // outputs: live coordinates while drawing, held coordinates otherwise
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    vga_plot = draw && sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
    vga_x = draw ? sx[X_W-1:0] : hx;
    vga_y = draw ? sy[Y_W-1:0] : hy;
    vga_colour = draw ? c0 : hc;
  end
  // capture the request so later input changes cannot disturb the draw
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x0 <= '0;
      y0 <= '0;
      w0 <= '0;
      h0 <= '0;
      c0 <= '0;
    end else if (accept) begin
      x0 <= x_in;
      y0 <= y_in;
      w0 <= w_in;
      h0 <= h_in;
      c0 <= colour_in;
    end
  // remember the last driven pixel so the adapter bus is stable outside DRAW
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hx <= '0;
      hy <= '0;
      hc <= '0;
    end else if (draw) begin
      hx <= sx[X_W-1:0];
      hy <= sy[Y_W-1:0];
      hc <= c0;
    end
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: directed and random draws checked against a per-pixel raster model
module tb_rect_plotter;
  logic clk = 0, resetn = 0, start = 0, abort = 0;
  logic [7:0] x_in = 0, w_in = 0, vga_x;
  logic [6:0] y_in = 0, h_in = 0, vga_y;
  logic [2:0] colour_in = 0, vga_colour;
  logic busy, done, vga_plot;
  int tests = 0, fails = 0;
  int lx = 0, ly = 0, lc = 0;

  rect_plotter dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in), .colour_in(colour_in),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input int ex, input int ey, input int ec);
    chk({tag, "_x"}, 32'(vga_x), 32'(ex));
    chk({tag, "_y"}, 32'(vga_y), 32'(ey));
    chk({tag, "_c"}, 32'(vga_colour), 32'(ec));
  endtask

  // One request: the model walks every pixel in raster order; ab is the pixel index at which to abort (-1 = none)
  task automatic run_draw(input int x, input int y, input int w, input int h, input int c, input int ab);
    int ex, ey;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    start = 1; abort = 0;
    x_in = 8'(x); y_in = 7'(y); w_in = 8'(w); h_in = 7'(h); colour_in = 3'(c);
    @(posedge clk); #1;
    start = 0;
    if (w == 0 || h == 0) begin
      @(negedge clk);
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 1);
      chk("zero_plot", 32'(vga_plot), 0);
      chk_bus("zero_hold", lx, ly, lc);
      @(posedge clk); #1;
      chk("zero_after_done", 32'(done), 0);
      chk("zero_after_busy", 32'(busy), 0);
      return;
    end
    for (int k = 0; k < w * h; k++) begin
      @(negedge clk);
      ex = x + k % w;
      ey = y + k / w;
      chk("plot", 32'(vga_plot), 32'(ex < 160 && ey < 120));
      lx = ex % 256; ly = ey % 128; lc = c;
      chk_bus("pix", lx, ly, lc);
      chk("draw_done", 32'(done), 0);
      chk("draw_busy", 32'(busy), 1);
      start = 1'($urandom);
      x_in = 8'($urandom); y_in = 7'($urandom); w_in = 8'($urandom); h_in = 7'($urandom);
      colour_in = 3'($urandom);
      if (k == ab) begin
        abort = 1;
        @(posedge clk); #1;
        abort = 0; start = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_plot", 32'(vga_plot), 0);
        chk("abort_done", 32'(done), 0);
        chk_bus("abort_hold", lx, ly, lc);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        return;
      end
    end
    start = 0;
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_plot", 32'(vga_plot), 0);
    chk_bus("done_hold", lx, ly, lc);
    @(posedge clk); #1;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    int w, h, n, ab;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk_bus("rst", 0, 0, 0);
    @(negedge clk); resetn = 1;
    run_draw(10, 20, 3, 2, 4, -1);
    run_draw(158, 119, 4, 2, 5, -1);
    run_draw(30, 40, 0, 5, 2, -1);
    run_draw(50, 60, 4, 4, 7, 4);
    run_draw(5, 6, 2, 2, 1, -1);
    run_draw(250, 125, 8, 6, 3, -1);
    @(negedge clk);
    start = 1; abort = 1; w_in = 3; h_in = 3;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("abort_wins_busy", 32'(busy), 0);
    @(negedge clk);
    chk("abort_wins_idle", 32'(busy), 0);
    for (int i = 0; i < 25; i++) begin
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 5);
      n = w * h;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      run_draw($urandom_range(0, 255), $urandom_range(0, 127), w, h, $urandom_range(0, 7), ab);
    end
    @(negedge clk);
    start = 1; abort = 0; x_in = 12; y_in = 13; w_in = 8; h_in = 8; colour_in = 6;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #3 resetn = 0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_plot", 32'(vga_plot), 0);
    chk_bus("async", 0, 0, 0);
    @(negedge clk); resetn = 1;
    lx = 0; ly = 0; lc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    run_draw(0, 0, 2, 3, 7, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
